thread_regfile: RTL and testbench
=================================

THREAD_REGFILE -- requirements
Module: thread_regfile

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, register and datapath width.
REQ-002 SHALL have parameter NUM_REGS, default 16, register count; power of two, at least 8.
REQ-003 SHALL have parameter THREADS_PER_BLOCK, default 4, value held in %blockDim.
REQ-004 SHALL have parameter THREAD_ID, default 0, value held in %threadIdx.
REQ-005 SHALL have parameter BLOCK_ID_BITS, default 8, width of block_id; AW = log2(NUM_REGS).
REQ-006 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port enable, input, 1, block enable; when low, no state changes except reset.
REQ-009 SHALL have ports block_id (input, BLOCK_ID_BITS) and core_state (input, 3): REQUEST=3'b011, UPDATE=3'b110, DONE=3'b111.
REQ-010 SHALL have port thread_active, input, 1, thread participates in the current block.
REQ-011 SHALL have ports decoded_rd_address, decoded_rs_address, decoded_rt_address, each input, AW.
REQ-012 SHALL have ports decoded_reg_write_enable, decoded_mem_read_enable (input, 1) and decoded_reg_input_mux (input, 2): 00 ARITHMETIC, 01 MEMORY, 10 CONSTANT, 11 reserved.
REQ-013 SHALL have ports decoded_immediate, alu_out, lsu_out, each input, DATA_BITS.
REQ-014 SHALL have ports lsu_valid (input, 1) and lsu_rd_address (input, AW): one-cycle load-return strobe and destination register.
REQ-015 SHALL have ports rs and rt, output, DATA_BITS, registered operands.
REQ-016 SHALL have ports hazard (output, 1, combinational operand-not-ready stall) and loads_pending (output, 1, registered OR of scoreboard).

Function
REQ-017 SHALL hold read-only special registers: NUM_REGS-1 = THREAD_ID, NUM_REGS-2 = THREADS_PER_BLOCK, NUM_REGS-3 = %blockIdx; values zero-extended or truncated to DATA_BITS.
REQ-018 SHALL load block_id into NUM_REGS-3 on the first enabled cycle while block_id_loaded is clear, then set block_id_loaded; core_state DONE clears it; if both occur in one cycle, the load happens and the flag ends clear.
REQ-019 SHALL keep a NUM_REGS-bit scoreboard of outstanding loads.
REQ-020 SHALL drive hazard high when enable, thread_active and core_state==REQUEST and any of pending[rs], pending[rt], or pending[rd] with (reg_write_enable or mem_read_enable), excluding any register returned by lsu_valid that same cycle.
REQ-021 SHALL, in REQUEST with thread_active and hazard low, latch rs/rt from the file; if lsu_valid targets that address in the same cycle, lsu_out is forwarded instead; latency one cycle.
REQ-022 SHALL, in REQUEST with hazard high, hold rs, rt and scoreboard unchanged.
REQ-023 SHALL, in REQUEST with thread_active low, load rs=rt=0 and assert no hazard.
REQ-024 SHALL, in REQUEST with hazard low, thread_active and decoded_mem_read_enable, set pending[rd] when rd < NUM_REGS-3.
REQ-025 SHALL, in UPDATE with thread_active and decoded_reg_write_enable and rd < NUM_REGS-3, write alu_out (00) or decoded_immediate (10); 01 performs no write; 11 writes zero.
REQ-026 SHALL, on lsu_valid with lsu_rd_address < NUM_REGS-3, write lsu_out and clear that pending bit regardless of core_state, thread_active or enable.
REQ-027 SHALL give the lsu_valid write priority over a same-cycle UPDATE write to the same register; same-cycle set and clear of one pending bit leaves it set.
REQ-028 SHALL ignore all writes to special registers and lsu_valid to a non-pending register except for the data write.

Reset
REQ-029 SHALL, while reset is low, clear rs, rt, registers 0..NUM_REGS-4, the scoreboard, loads_pending, block_id_loaded and %blockIdx, and preset %blockDim and %threadIdx.
REQ-030 SHALL drop outstanding loads on reset; a later lsu_valid still writes data but finds no pending bit.

Structure
REQ-031 SHALL take core_state encodings and reg_input_mux encodings from the shared GPU package.
REQ-032 SHALL place the scoreboard and hazard logic in sub-module reg_scoreboard.

Verification
REQ-033 SHALL cover: reset low, release -> rs=rt=0, R14=4, R15=THREAD_ID, first enable loads block_id=0x2A into R13.
REQ-034 SHALL cover: CONSTANT write 0x55 to R3 in UPDATE, then read rs=R3 in REQUEST -> rs=0x55 one cycle later.
REQ-035 SHALL cover: load to R5, next REQUEST reads R5 -> hazard=1, rs held; lsu_valid R5=0x77 -> hazard=0, rs=0x77 same cycle forward.
REQ-036 SHALL cover: UPDATE write to R15 and lsu_valid to R13 -> both unchanged.
REQ-037 SHALL cover: UPDATE ALU write 0x11 and lsu_valid 0x22 to R2 same cycle -> R2=0x22.
REQ-038 SHALL cover: NUM_REGS=32, DATA_BITS=16 -> R31=THREAD_ID, R29 holds block_id, R28 writable.

Source files
------------

// File: rtl/thread_regfile_pkg.sv
// Shared GPU encodings: core pipeline states and register write-back source select.
// Imported by the thread register file and its scoreboard.
package thread_regfile_pkg;

  typedef enum logic [2:0] {
    CORE_IDLE    = 3'b000,
    CORE_FETCH   = 3'b001,
    CORE_DECODE  = 3'b010,
    CORE_REQUEST = 3'b011,
    CORE_WAIT    = 3'b100,
    CORE_EXECUTE = 3'b101,
    CORE_UPDATE  = 3'b110,
    CORE_DONE    = 3'b111
  } core_state_e;

  typedef enum logic [1:0] {
    MUX_ARITHMETIC = 2'b00,
    MUX_MEMORY     = 2'b01,
    MUX_CONSTANT   = 2'b10,
    MUX_RESERVED   = 2'b11
  } reg_input_mux_e;

  // The top three register addresses are read-only specials.
  localparam int NUM_SPECIAL_REGS = 3;

endpackage

// File: rtl/reg_scoreboard.sv
// Outstanding-load scoreboard and operand hazard detection for one thread.
// A load return in the same cycle masks its register out of the hazard check.
module reg_scoreboard
  import thread_regfile_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable_i,
  input  logic          thread_active_i,
  input  logic [2:0]    core_state_i,
  input  logic [AW-1:0] rs_addr_i,
  input  logic [AW-1:0] rt_addr_i,
  input  logic [AW-1:0] rd_addr_i,
  input  logic          reg_write_en_i,
  input  logic          mem_read_en_i,
  input  logic          lsu_valid_i,
  input  logic [AW-1:0] lsu_rd_addr_i,
  output logic          hazard_o,
  output logic          loads_pending_o
);

  localparam logic [AW-1:0] FIRST_SPECIAL = AW'(NUM_REGS - NUM_SPECIAL_REGS);

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [NUM_REGS-1:0] returning, pending_eff;
  logic                loads_pending_q;
  logic                request_cycle, load_issue;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    returning = '0;
    if (lsu_valid_i) returning[lsu_rd_addr_i] = 1'b1;
    pending_eff   = pending_q & ~returning;
    request_cycle = enable_i && thread_active_i && (core_state_i == CORE_REQUEST);
    hazard_o      = request_cycle &&
                    (pending_eff[rs_addr_i] || pending_eff[rt_addr_i] ||
                     ((reg_write_en_i || mem_read_en_i) && pending_eff[rd_addr_i]));
    load_issue    = request_cycle && !hazard_o && mem_read_en_i &&
                    (rd_addr_i < FIRST_SPECIAL);
    // Set is applied after clear so a same-cycle issue and return leaves the bit set.
    pending_d = pending_q & ~returning;
    if (load_issue) pending_d[rd_addr_i] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q       <= '0;
      loads_pending_q <= 1'b0;
    end else begin
      pending_q       <= pending_d;
      loads_pending_q <= |pending_d;
    end
  end

  assign loads_pending_o = loads_pending_q;

endmodule

// File: rtl/thread_regfile.sv
// Per-thread register file with read-only %blockIdx/%blockDim/%threadIdx specials,
// registered operand reads with load-return forwarding, and scoreboarded load tracking.
module thread_regfile
  import thread_regfile_pkg::*;
#(
  parameter int  DATA_BITS         = 8,
  parameter int  NUM_REGS          = 16,
  parameter int  THREADS_PER_BLOCK = 4,
  parameter int  THREAD_ID         = 0,
  parameter int  BLOCK_ID_BITS     = 8,
  localparam int AW                = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [BLOCK_ID_BITS-1:0] block_id,
  input  logic [2:0]               core_state,
  input  logic                     thread_active,
  input  logic [AW-1:0]            decoded_rd_address,
  input  logic [AW-1:0]            decoded_rs_address,
  input  logic [AW-1:0]            decoded_rt_address,
  input  logic                     decoded_reg_write_enable,
  input  logic                     decoded_mem_read_enable,
  input  logic [1:0]               decoded_reg_input_mux,
  input  logic [DATA_BITS-1:0]     decoded_immediate,
  input  logic [DATA_BITS-1:0]     alu_out,
  input  logic [DATA_BITS-1:0]     lsu_out,
  input  logic                     lsu_valid,
  input  logic [AW-1:0]            lsu_rd_address,
  output logic [DATA_BITS-1:0]     rs,
  output logic [DATA_BITS-1:0]     rt,
  output logic                     hazard,
  output logic                     loads_pending
);

  localparam logic [AW-1:0]        BLOCK_IDX_ADDR  = AW'(NUM_REGS - 3);
  localparam logic [AW-1:0]        BLOCK_DIM_ADDR  = AW'(NUM_REGS - 2);
  localparam logic [AW-1:0]        THREAD_IDX_ADDR = AW'(NUM_REGS - 1);
  localparam logic [DATA_BITS-1:0] BLOCK_DIM_VAL   = DATA_BITS'(THREADS_PER_BLOCK);
  localparam logic [DATA_BITS-1:0] THREAD_IDX_VAL  = DATA_BITS'(THREAD_ID);

  logic [DATA_BITS-1:0] regs_q [NUM_REGS];
  logic [DATA_BITS-1:0] regs_d [NUM_REGS];
  logic [DATA_BITS-1:0] rs_q, rs_d, rt_q, rt_d;
  logic [DATA_BITS-1:0] upd_data;
  logic                 block_id_loaded_q, block_id_loaded_d;
  logic                 block_load, upd_write, lsu_write;

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .AW       (AW)
  ) u_scoreboard (
    .clk             (clk),
    .rst_n           (reset),
    .enable_i        (enable),
    .thread_active_i (thread_active),
    .core_state_i    (core_state),
    .rs_addr_i       (decoded_rs_address),
    .rt_addr_i       (decoded_rt_address),
    .rd_addr_i       (decoded_rd_address),
    .reg_write_en_i  (decoded_reg_write_enable),
    .mem_read_en_i   (decoded_mem_read_enable),
    .lsu_valid_i     (lsu_valid),
    .lsu_rd_addr_i   (lsu_rd_address),
    .hazard_o        (hazard),
    .loads_pending_o (loads_pending)
  );

  // A returning load to a writable register is forwarded over the stored value.
  function automatic logic [DATA_BITS-1:0] read_operand(input logic [AW-1:0] addr);
    if (lsu_write && (lsu_rd_address == addr)) return lsu_out;
    return regs_q[addr];
  endfunction

  always_comb begin
    block_load = enable && !block_id_loaded_q;
    block_id_loaded_d = block_id_loaded_q;
    if (enable) begin
      if (core_state == CORE_DONE) block_id_loaded_d = 1'b0;
      else if (!block_id_loaded_q) block_id_loaded_d = 1'b1;
    end

    lsu_write = lsu_valid && (lsu_rd_address < BLOCK_IDX_ADDR);
    upd_write = enable && (core_state == CORE_UPDATE) && thread_active &&
                decoded_reg_write_enable && (decoded_rd_address < BLOCK_IDX_ADDR) &&
                (decoded_reg_input_mux != MUX_MEMORY);
    case (decoded_reg_input_mux)
      MUX_ARITHMETIC: upd_data = alu_out;
      MUX_CONSTANT:   upd_data = decoded_immediate;
      default:        upd_data = '0;
    endcase

    regs_d = regs_q;
    if (upd_write)  regs_d[decoded_rd_address] = upd_data;
    if (lsu_write)  regs_d[lsu_rd_address] = lsu_out;
    if (block_load) regs_d[BLOCK_IDX_ADDR] = DATA_BITS'(block_id);

    rs_d = rs_q;
    rt_d = rt_q;
    if (enable && (core_state == CORE_REQUEST)) begin
      if (!thread_active) begin
        rs_d = '0;
        rt_d = '0;
      end else if (!hazard) begin
        rs_d = read_operand(decoded_rs_address);
        rt_d = read_operand(decoded_rt_address);
      end
    end
  end

  // NOTE: the file is small, so every entry is reset; specials come up preset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS - 2; i++) regs_q[i] <= '0;
      regs_q[BLOCK_DIM_ADDR]  <= BLOCK_DIM_VAL;
      regs_q[THREAD_IDX_ADDR] <= THREAD_IDX_VAL;
      rs_q                    <= '0;
      rt_q                    <= '0;
      block_id_loaded_q       <= 1'b0;
    end else begin
      regs_q            <= regs_d;
      rs_q              <= rs_d;
      rt_q              <= rt_d;
      block_id_loaded_q <= block_id_loaded_d;
    end
  end

  assign rs = rs_q;
  assign rt = rt_q;

endmodule

// File: tb/tb_thread_regfile.sv
// Directed bench for thread_regfile: a vector table plus hand-written sequences for
// block_id reload, reset dropping loads, and a 32-register 16-bit instance.
module tb_thread_regfile;

  localparam logic [2:0] ST_IDLE = 3'b000;
  localparam logic [2:0] ST_REQ  = 3'b011;
  localparam logic [2:0] ST_UPD  = 3'b110;
  localparam logic [2:0] ST_DONE = 3'b111;
  localparam logic [1:0] M_ALU   = 2'b00;
  localparam logic [1:0] M_MEM   = 2'b01;
  localparam logic [1:0] M_CONST = 2'b10;
  localparam logic [1:0] M_RSV   = 2'b11;

  typedef struct {
    logic       en;
    logic [2:0] st;
    logic       ta;
    logic       we;
    logic       mre;
    logic [1:0] mux;
    logic [3:0] rd;
    logic [3:0] rsa;
    logic [3:0] rta;
    logic [7:0] imm;
    logic [7:0] alu;
    logic       lv;
    logic [3:0] lrd;
    logic [7:0] lout;
    logic       e_hz;
    logic [7:0] e_rs;
    logic [7:0] e_rt;
    logic       e_lp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] block_id;
  logic [2:0] core_state;
  logic       thread_active;
  logic [3:0] rd_a, rs_a, rt_a;
  logic       we, mre;
  logic [1:0] mux;
  logic [7:0] imm, alu, lout;
  logic       lv;
  logic [3:0] lrd;
  logic [7:0] rs, rt;
  logic       hazard, loads_pending;

  logic        en2, ta2, we2, mre2, lv2;
  logic [2:0]  st2;
  logic [7:0]  bid2;
  logic [4:0]  rd2, rs2a, rt2a, lrd2;
  logic [1:0]  mux2;
  logic [15:0] imm2, alu2, lout2;
  logic [15:0] rs2, rt2;
  logic        hazard2, lp2;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  thread_regfile #(
    .DATA_BITS(8), .NUM_REGS(16), .THREADS_PER_BLOCK(4), .THREAD_ID(3), .BLOCK_ID_BITS(8)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .block_id(block_id), .core_state(core_state),
    .thread_active(thread_active), .decoded_rd_address(rd_a), .decoded_rs_address(rs_a),
    .decoded_rt_address(rt_a), .decoded_reg_write_enable(we), .decoded_mem_read_enable(mre),
    .decoded_reg_input_mux(mux), .decoded_immediate(imm), .alu_out(alu), .lsu_out(lout),
    .lsu_valid(lv), .lsu_rd_address(lrd), .rs(rs), .rt(rt), .hazard(hazard),
    .loads_pending(loads_pending)
  );

  thread_regfile #(
    .DATA_BITS(16), .NUM_REGS(32), .THREADS_PER_BLOCK(4), .THREAD_ID(5), .BLOCK_ID_BITS(8)
  ) dut32 (
    .clk(clk), .reset(reset), .enable(en2), .block_id(bid2), .core_state(st2),
    .thread_active(ta2), .decoded_rd_address(rd2), .decoded_rs_address(rs2a),
    .decoded_rt_address(rt2a), .decoded_reg_write_enable(we2), .decoded_mem_read_enable(mre2),
    .decoded_reg_input_mux(mux2), .decoded_immediate(imm2), .alu_out(alu2), .lsu_out(lout2),
    .lsu_valid(lv2), .lsu_rd_address(lrd2), .rs(rs2), .rt(rt2), .hazard(hazard2),
    .loads_pending(lp2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic en, input logic [2:0] st, input logic ta, input logic w, input logic m,
    input logic [1:0] mx, input logic [3:0] d, input logic [3:0] s, input logic [3:0] t,
    input logic [7:0] im, input logic [7:0] al, input logic l, input logic [3:0] ld,
    input logic [7:0] lo, input logic ehz, input logic [7:0] ers, input logic [7:0] ert,
    input logic elp);
    vec_t v;
    v.en = en; v.st = st; v.ta = ta; v.we = w; v.mre = m; v.mux = mx; v.rd = d;
    v.rsa = s; v.rta = t; v.imm = im; v.alu = al; v.lv = l; v.lrd = ld; v.lout = lo;
    v.e_hz = ehz; v.e_rs = ers; v.e_rt = ert; v.e_lp = elp;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    enable = v.en; core_state = v.st; thread_active = v.ta; we = v.we; mre = v.mre;
    mux = v.mux; rd_a = v.rd; rs_a = v.rsa; rt_a = v.rta; imm = v.imm; alu = v.alu;
    lv = v.lv; lrd = v.lrd; lout = v.lout;
    #1;
    check({tag, " hazard"}, 32'(hazard), 32'(v.e_hz));
    @(posedge clk);
    #1;
    check({tag, " rs"}, 32'(rs), 32'(v.e_rs));
    check({tag, " rt"}, 32'(rt), 32'(v.e_rt));
    check({tag, " loads_pending"}, 32'(loads_pending), 32'(v.e_lp));
  endtask

  task automatic idle_inputs();
    enable = 1'b0; core_state = ST_IDLE; thread_active = 1'b0; we = 1'b0; mre = 1'b0;
    mux = M_ALU; rd_a = '0; rs_a = '0; rt_a = '0; imm = '0; alu = '0; lv = 1'b0;
    lrd = '0; lout = '0;
  endtask

  initial begin
    reset = 1'b0;
    block_id = 8'h2A;
    idle_inputs();
    en2 = 0; st2 = ST_IDLE; ta2 = 0; we2 = 0; mre2 = 0; lv2 = 0; bid2 = 8'hA5;
    rd2 = '0; rs2a = '0; rt2a = '0; lrd2 = '0; mux2 = M_ALU; imm2 = '0; alu2 = '0; lout2 = '0;

    //  en st      ta we mre mux     rd  rs  rt  imm    alu    lv lrd lout   hz rs     rt     lp
    vecs.push_back(mk(1, ST_IDLE, 0, 0, 0, M_ALU,   0,  0,  0,  8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0));
    vecs.push_back(mk(1, ST_REQ,  1, 0, 0, M_ALU,   0, 15, 14,  8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h03, 8'h04, 0));
    vecs.push_back(mk(1, ST_REQ,  1, 0, 0, M_ALU,   0, 13,  0,  8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h2A, 8'h00, 0));
    vecs.push_back(mk(1, ST_UPD,  1, 1, 0, M_CONST, 3,  0,  0,  8'h55, 8'h00, 0, 0, 8'h00, 0, 8'h2A, 8'h00, 0));
    vecs.push_back(mk(1, ST_REQ,  1, 0, 0, M_ALU,   0,  3,  3,  8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h55, 8'h55, 0));
    vecs.push_back(mk(1, ST_UPD,  1, 1, 0, M_ALU,   4,  0,  0,  8'h00, 8'h99, 0, 0, 8'h00, 0, 8'h55, 8'h55, 0));
    vecs.push_back(mk(1, ST_UPD,  1, 1, 0, M_RSV,   3,  0,  0,  8'h77, 8'h66, 0, 0, 8'h00, 0, 8'h55, 8'h55, 0));
    vecs.push_back(mk(1, ST_UPD,  1, 1, 0, M_MEM,   4,  0,  0,  8'h12, 8'h12, 0, 0, 8'h00, 0, 8'h55, 8'h55, 0));
    vecs.push_back(mk(1, ST_REQ,  1, 0, 0, M_ALU,   0,  4,  3,  8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h99, 8'h00, 0));
    vecs.push_back(mk(1, ST_REQ,  1, 0, 1, M_MEM,   5,  4,  4,  8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h99, 8'h99, 1));
    vecs.push_back(mk(1, ST_REQ,  1, 0, 0, M_ALU,   0,  5,  3,  8'h00, 8'h00, 0, 0, 8'h00, 1, 8'h99, 8'h99, 1));
    vecs.push_back(mk(1, ST_REQ,  1, 0, 0, M_ALU,   0,  5,  3,  8'h00, 8'h00, 1, 5, 8'h77, 0, 8'h77, 8'h00, 0));
    vecs.push_back(mk(1, ST_REQ,  0, 0, 0, M_ALU,   0,  4,  4,  8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0));
    vecs.push_back(mk(1, ST_UPD,  1, 1, 0, M_ALU,  15,  0,  0,  8'h00, 8'hEE, 1, 13, 8'h33, 0, 8'h00, 8'h00, 0));
    vecs.push_back(mk(1, ST_REQ,  1, 0, 0, M_ALU,   0, 15, 13,  8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h03, 8'h2A, 0));
    vecs.push_back(mk(1, ST_UPD,  1, 1, 0, M_ALU,   2,  0,  0,  8'h00, 8'h11, 1, 2, 8'h22, 0, 8'h03, 8'h2A, 0));
    vecs.push_back(mk(1, ST_REQ,  1, 0, 0, M_ALU,   0,  2,  2,  8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h22, 8'h22, 0));
    vecs.push_back(mk(1, ST_REQ,  1, 0, 1, M_MEM,   6,  0,  0,  8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h00, 8'h00, 1));
    vecs.push_back(mk(1, ST_REQ,  1, 1, 0, M_ALU,   6,  2,  2,  8'h00, 8'h00, 0, 0, 8'h00, 1, 8'h00, 8'h00, 1));
    vecs.push_back(mk(1, ST_REQ,  1, 0, 0, M_ALU,   6,  2,  2,  8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h22, 8'h22, 1));
    vecs.push_back(mk(1, ST_IDLE, 0, 0, 0, M_ALU,   0,  0,  0,  8'h00, 8'h00, 1, 6, 8'h44, 0, 8'h22, 8'h22, 0));
    vecs.push_back(mk(1, ST_REQ,  1, 0, 0, M_ALU,   0,  6, 13,  8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h44, 8'h2A, 0));
    vecs.push_back(mk(1, ST_REQ,  1, 0, 1, M_MEM,   7,  0,  0,  8'h00, 8'h00, 1, 7, 8'h10, 0, 8'h00, 8'h00, 1));
    vecs.push_back(mk(1, ST_IDLE, 0, 0, 0, M_ALU,   0,  0,  0,  8'h00, 8'h00, 1, 7, 8'h20, 0, 8'h00, 8'h00, 0));
    vecs.push_back(mk(1, ST_REQ,  1, 0, 0, M_ALU,   0,  7,  5,  8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h20, 8'h77, 0));
    vecs.push_back(mk(1, ST_REQ,  1, 0, 1, M_MEM,  14,  0, 14,  8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h00, 8'h04, 0));
    vecs.push_back(mk(0, ST_UPD,  1, 1, 0, M_CONST, 3,  0,  0,  8'hAB, 8'h00, 0, 0, 8'h00, 0, 8'h00, 8'h04, 0));
    vecs.push_back(mk(0, ST_REQ,  1, 0, 0, M_ALU,   0,  3,  3,  8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h00, 8'h04, 0));
    vecs.push_back(mk(1, ST_REQ,  1, 0, 0, M_ALU,   0,  3,  3,  8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0));

    // Reset state, then release.
    repeat (2) @(posedge clk);
    #1;
    check("in_reset rs", 32'(rs), 32'h0);
    check("in_reset loads_pending", 32'(loads_pending), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("post_reset rs", 32'(rs), 32'h0);
    check("post_reset rt", 32'(rt), 32'h0);
    check("post_reset hazard", 32'(hazard), 32'h0);

    foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

    // block_id reload around DONE, including load and DONE in the same cycle.
    block_id = 8'h5C;
    apply(mk(1, ST_DONE, 0, 0, 0, M_ALU, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0), "done1");
    apply(mk(1, ST_IDLE, 0, 0, 0, M_ALU, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0), "reload");
    block_id = 8'h11;
    apply(mk(1, ST_REQ, 1, 0, 0, M_ALU, 0, 13, 14, 0, 0, 0, 0, 0, 0, 8'h5C, 8'h04, 0), "bid_held");
    block_id = 8'h66;
    apply(mk(1, ST_DONE, 0, 0, 0, M_ALU, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h5C, 8'h04, 0), "done2");
    apply(mk(1, ST_DONE, 0, 0, 0, M_ALU, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h5C, 8'h04, 0), "done_load");
    block_id = 8'h77;
    apply(mk(1, ST_REQ, 1, 0, 0, M_ALU, 0, 13, 13, 0, 0, 0, 0, 0, 0, 8'h66, 8'h66, 0), "bid_66");
    apply(mk(1, ST_REQ, 1, 0, 0, M_ALU, 0, 13, 13, 0, 0, 0, 0, 0, 0, 8'h77, 8'h77, 0), "bid_77");

    // Reset drops an outstanding load; its later return still writes data.
    apply(mk(1, ST_REQ, 1, 0, 1, M_MEM, 8, 0, 14, 0, 0, 0, 0, 0, 0, 8'h00, 8'h04, 1), "ld8");
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    #1;
    check("mid_reset rs", 32'(rs), 32'h0);
    check("mid_reset rt", 32'(rt), 32'h0);
    check("mid_reset loads_pending", 32'(loads_pending), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    block_id = 8'h3C;
    apply(mk(1, ST_IDLE, 0, 0, 0, M_ALU, 0, 0, 0, 0, 0, 1, 8, 8'h66, 0, 8'h00, 8'h00, 0), "late_ret");
    apply(mk(1, ST_REQ, 1, 0, 0, M_ALU, 0, 8, 13, 0, 0, 0, 0, 0, 0, 8'h66, 8'h3C, 0), "rd_r8");

    // Wide instance: 32 registers, 16-bit data.
    @(negedge clk);
    idle_inputs();
    en2 = 1'b1; st2 = ST_IDLE;
    @(negedge clk);
    st2 = ST_REQ; ta2 = 1'b1; rs2a = 5'd31; rt2a = 5'd29;
    @(posedge clk);
    #1;
    check("w32 r31", 32'(rs2), 32'h0005);
    check("w32 r29", 32'(rt2), 32'h00A5);
    @(negedge clk);
    st2 = ST_UPD; we2 = 1'b1; mux2 = M_CONST; rd2 = 5'd28; imm2 = 16'hBEEF;
    @(negedge clk);
    st2 = ST_UPD; rd2 = 5'd29; imm2 = 16'h1234;
    @(negedge clk);
    st2 = ST_REQ; we2 = 1'b0; rs2a = 5'd28; rt2a = 5'd29;
    @(posedge clk);
    #1;
    check("w32 r28", 32'(rs2), 32'hBEEF);
    check("w32 r29 ro", 32'(rt2), 32'h00A5);
    @(negedge clk);
    rs2a = 5'd30; rt2a = 5'd31;
    @(posedge clk);
    #1;
    check("w32 r30", 32'(rs2), 32'h0004);
    check("w32 r31b", 32'(rt2), 32'h0005);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
